// File: rtl/arb_types.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : arb_types
// Brief    : State/grant encodings and line-offset helper for cache_mem_arbiter
// Revision : 1.0
// ----------------------------------------------------------------------------
package arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  localparam int LINE_W_DEFAULT = 256;
  localparam int OFFSET_W       = $clog2(LINE_W_DEFAULT / 8);

  // Number of byte-offset bits inside one cache line of line_w bits.
  function automatic int offset_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_grant_sel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : arb_grant_sel
// Brief    : Picks the winner among I/D requests; ARB_RR_EN selects round-robin,
//            otherwise the D-cache always wins a tie.
// Revision : 1.0
// ----------------------------------------------------------------------------
module arb_grant_sel
  import arb_types::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant
);

`ifdef ARB_RR_EN
  always_comb begin
    grant = GRANT_I;
    if (i_req && d_req) begin
      // On a tie the requester that was not served last goes first.
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req) begin
      grant = GRANT_D;
    end
  end
`else
  logic [1:0] unused_inputs;
  assign unused_inputs = {i_req, last_grant};

  always_comb begin
    grant = d_req ? GRANT_D : GRANT_I;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : cache_mem_arbiter
// Brief    : Shares the physical-memory port between I-cache and D-cache.
//            Define ARB_RR_EN for round-robin ties (default: D-cache priority).
// Revision : 1.0
// ----------------------------------------------------------------------------
module cache_mem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,

  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int              OFS_W     = offset_bits(LINE_W);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFS_W;

  state_e state;
  logic   i_req;
  logic   d_req;
  logic   grant;
  logic   last_grant;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_I;
    end else if (pmem_resp && (state == SERVE_I)) begin
      last_grant <= GRANT_I;
    end else if (pmem_resp && (state == SERVE_D)) begin
      last_grant <= GRANT_D;
    end
  end
`else
  assign last_grant = GRANT_I;
`endif

  arb_grant_sel u_grant_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Read data is broadcast; only the resp pulse tells a cache it is its line.
  assign icache_rdata = pmem_rdata;
  assign dcache_rdata = pmem_rdata;
  assign icache_resp  = (state == SERVE_I) && pmem_resp;
  assign dcache_resp  = (state == SERVE_D) && pmem_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            if (grant == GRANT_D) begin
              state        <= SERVE_D;
              // A simultaneous read+write from the D-cache is treated as a write.
              pmem_read    <= dcache_read & ~dcache_write;
              pmem_write   <= dcache_write;
              pmem_address <= dcache_address & ADDR_MASK;
              pmem_wdata   <= dcache_wdata;
            end else begin
              state        <= SERVE_I;
              pmem_read    <= 1'b1;
              pmem_write   <= 1'b0;
              pmem_address <= icache_address & ADDR_MASK;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          pmem_read    <= 1'b0;
          pmem_write   <= 1'b0;
          pmem_address <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_cache_mem_arbiter
// Brief    : Scoreboard bench for cache_mem_arbiter with a latency-variable
//            memory model; honours ARB_RR_EN for the tie policy.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int LINE_W     = 256;
  localparam int LINE_BYTES = LINE_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;
  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         rd;
    logic         wr;
    logic [255:0] wdata;
  } req_t;

  req_t         iq[$];
  req_t         dq[$];
  req_t         cur;
  logic [255:0] ref_mem [logic [31:0]];
  logic [255:0] mem     [logic [31:0]];
  int           grant_log[$];

  int checks = 0, failures = 0;
  int fix_lat = 0;
  bit spur_en = 1'b0;
  bit log_en  = 1'b0;
  int i_issued = 0, d_issued = 0, i_done = 0, d_done = 0;
  int owner = 0;       // 0 none, 1 I-cache, 2 D-cache
  int last  = 1;
  bit p_i = 1'b0, p_d = 1'b0, p_r = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] aln(input logic [31:0] a);
    return a - (a % 32'(LINE_BYTES));
  endfunction

  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(k + 1));
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h0800_0000 | (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31));
  endfunction

  function automatic logic [255:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  function automatic int pick(input bit ri, input bit rd, input int lst);
`ifdef ARB_RR_EN
    if (ri && rd) return (lst == 1) ? 2 : 1;
`endif
    return rd ? 2 : 1;
  endfunction

  // Memory model: resp after a per-transaction latency, optional stray resp when idle.
  initial begin : memory_model
    int cnt;
    int lat;
    cnt = 0;
    lat = 1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp  = 1'b0;
      pmem_rdata = rand_line();
      if (rst) begin
        cnt = 0;
      end else if (pmem_read || pmem_write) begin
        if (cnt == 0) lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 4));
        cnt++;
        if (cnt >= lat) begin
          pmem_resp = 1'b1;
          cnt = 0;
          if (pmem_write) mem[pmem_address] = pmem_wdata;
          else pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : pattern(pmem_address);
        end
      end else begin
        cnt = 0;
        if (spur_en && $urandom_range(0, 7) == 0) pmem_resp = 1'b1;
      end
    end
  end

  // Monitor: tracks who owns the port from the observed requests and checks every cycle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        owner = 0;
        last  = 1;
      end else if (owner == 0) begin
        if (p_i || p_d) begin
          owner = pick(p_i, p_d, last);
          if (log_en) grant_log.push_back(owner);
          if (owner == 1 && iq.size() > 0) cur = iq.pop_front();
          else if (owner == 2 && dq.size() > 0) cur = dq.pop_front();
          else chk("grant_without_request", 256'(owner), 256'(0));
        end
      end else if (p_r) begin
        last  = owner;
        owner = 0;
      end

      chk("icache_rdata_bcast", icache_rdata, pmem_rdata);
      chk("dcache_rdata_bcast", dcache_rdata, pmem_rdata);
      if (owner == 0) begin
        chk("idle_pmem_read", 256'(pmem_read), 256'(0));
        chk("idle_pmem_write", 256'(pmem_write), 256'(0));
        chk("idle_pmem_address", 256'(pmem_address), 256'(0));
        chk("idle_icache_resp", 256'(icache_resp), 256'(0));
        chk("idle_dcache_resp", 256'(dcache_resp), 256'(0));
      end else begin
        chk("pmem_read", 256'(pmem_read), 256'(cur.rd));
        chk("pmem_write", 256'(pmem_write), 256'(cur.wr));
        chk("pmem_address", 256'(pmem_address), 256'(cur.addr));
        if (owner == 2) chk("pmem_wdata", pmem_wdata, cur.wdata);
        chk("icache_resp", 256'(icache_resp), 256'(owner == 1 && pmem_resp));
        chk("dcache_resp", 256'(dcache_resp), 256'(owner == 2 && pmem_resp));
        if (pmem_resp) begin
          if (cur.wr) ref_mem[cur.addr] = cur.wdata;
          else if (owner == 1) chk("icache_rdata", icache_rdata, ref_get(cur.addr));
          else chk("dcache_rdata", dcache_rdata, ref_get(cur.addr));
        end
      end
      p_i = icache_read;
      p_d = dcache_read | dcache_write;
      p_r = pmem_resp;
    end
  end

  task automatic wait_resp(input bit is_d, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (is_d ? dcache_resp : icache_resp) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_resp_timeout: actual=none required=resp within 300 cycles",
               is_d ? "dcache" : "icache");
    end else if (is_d) d_done++;
    else i_done++;
  endtask

  task automatic i_seq(input logic [31:0] a, output int cyc);
    @(posedge clk); #1;
    icache_address = a;
    icache_read    = 1'b1;
    iq.push_back('{addr: aln(a), rd: 1'b1, wr: 1'b0, wdata: '0});
    i_issued++;
    wait_resp(1'b0, cyc);
    @(posedge clk); #1;
    icache_read = 1'b0;
  endtask

  // op: 0 read, 1 write, 2 read+write, negative = random op and address.
  // The request stays asserted between the n back-to-back transactions.
  task automatic d_seq(input int n, input int op, input logic [31:0] a0, input bit rnd_data);
    logic [31:0]  a;
    logic [255:0] wd;
    int           o, cyc;
    bit           r, w;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      o  = (op < 0) ? int'($urandom_range(0, 2)) : op;
      r  = (o != 1);
      w  = (o != 0);
      a  = (op < 0) ? rand_addr() : a0 + 32'(32 * k);
      wd = rnd_data ? rand_line() : {32{8'hA5}};
      dcache_address = a;
      dcache_wdata   = wd;
      dcache_read    = r;
      dcache_write   = w;
      dq.push_back('{addr: aln(a), rd: r & ~w, wr: w, wdata: wd});
      d_issued++;
      wait_resp(1'b1, cyc);
    end
    @(posedge clk); #1;
    dcache_read  = 1'b0;
    dcache_write = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    failures++;
    $display("FAIL watchdog: actual=still running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cyc;
    bit seen;
    rst            = 1'b1;
    icache_read    = 1'b0;
    icache_address = '0;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    dcache_address = '0;
    dcache_wdata   = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_pmem_wdata", pmem_wdata, 256'(0));
    chk("reset_pmem_read", 256'(pmem_read), 256'(0));

    // Lone I-read with a 3-cycle memory.
    fix_lat = 3;
    i_seq(32'h0000_0047, cyc);
    chk("iread_latency", 256'(cyc), 256'(4));

    // D write-back of a constant line.
    fix_lat = 0;
    d_seq(1, 1, 32'h1000_0000, 1'b0);

    // Reset pulse in the middle of an I-cache read.
    fix_lat = 4;
    @(posedge clk); #1;
    icache_address = 32'h2345_6789;
    icache_read    = 1'b1;
    iq.push_back('{addr: aln(32'h2345_6789), rd: 1'b1, wr: 1'b0, wdata: '0});
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (pmem_read) seen = 1'b1;
    end
    chk("rst_test_started", 256'(seen), 256'(1));
    @(negedge clk);
    #2;
    rst         = 1'b1;
    icache_read = 1'b0;
    #1;
    chk("async_rst_pmem_read", 256'(pmem_read), 256'(0));
    chk("async_rst_pmem_address", 256'(pmem_address), 256'(0));
    chk("async_rst_pmem_wdata", pmem_wdata, 256'(0));
    chk("async_rst_icache_resp", 256'(icache_resp), 256'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    fix_lat = 0;
    i_seq(32'h2345_6789, cyc);

    // Three simultaneous I/D requests, D re-requesting back-to-back.
    log_en = 1'b1;
    fork
      i_seq(32'h0000_0300, cyc);
      d_seq(3, 0, 32'h0000_0400, 1'b1);
    join
    log_en = 1'b0;
    chk("tie_grant_count", 256'(grant_log.size() >= 3), 256'(1));
    if (grant_log.size() >= 3) begin
`ifdef ARB_RR_EN
      chk("tie_order", 256'(grant_log[0] * 100 + grant_log[1] * 10 + grant_log[2]), 256'(212));
`else
      chk("tie_order", 256'(grant_log[0] * 100 + grant_log[1] * 10 + grant_log[2]), 256'(222));
`endif
    end

    // D-cache asserting read and write together.
    d_seq(1, 2, 32'h0000_0520, 1'b1);

    // Random concurrent traffic with stray memory responses while idle.
    spur_en = 1'b1;
    fork
      begin
        int c;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          i_seq(rand_addr(), c);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          d_seq(1, -1, 32'h0, 1'b1);
        end
      end
    join
    spur_en = 1'b0;
    repeat (4) @(negedge clk);

    chk("iq_drained", 256'(iq.size()), 256'(0));
    chk("dq_drained", 256'(dq.size()), 256'(0));
    chk("i_completions", 256'(i_done), 256'(i_issued));
    chk("d_completions", 256'(d_done), 256'(d_issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
